seq_div: RTL and testbench

Iterative 32-bit divider, the division counterpart of the combinational `Mult` unit in the execute stage. It serves DIV/DIVU and returns quotient in `Lo` and remainder in `Hi`, matching the multiplier's HI/LO convention. The core is a restoring shift-subtract datapath that produces one quotient bit per cycle. A start/busy/done handshake lets the pipeline control stall the EX stage while a division is in flight.

---
 rtl/seq_div.sv | 148 ++++++++++++++
 tb/tb_seq_div.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div -- iterative 32-bit restoring divider for DIV/DIVU.
//
// Produces one quotient bit per cycle on operand magnitudes, then applies
// the signs in a final fix-up cycle (truncation toward zero, remainder takes
// the dividend's sign). Quotient is returned on Lo, remainder on Hi.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; aborts any division
//   ena    in   block enable: gates start acceptance and the Hi/Lo outputs
//   sign   in   1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   start  in   division request, accepted only in IDLE with ena high
//   a      in   dividend, sampled with start
//   b      in   divisor, sampled with start
//   Hi     out  remainder (reads 0 while ena is low)
//   Lo     out  quotient  (reads 0 while ena is low)
//   busy   out  high from the accepting edge until the return to IDLE
//   done   out  one-cycle pulse in the cycle the new Hi/Lo appear
//
// state | meaning
// IDLE  | waiting for start & ena
// CALC  | 32 shift-subtract iterations
// FIX   | first cycle: apply signs / div-by-zero, write results, raise done
//       | second cycle: done visible, then return to IDLE
// ---------------------------------------------------------------------------
module seq_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        sign,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] babs_q;
    logic [31:0] a_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        bzero_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] aabs;
    logic [31:0] babs;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    always_comb begin
        aabs = (sign && a[31]) ? -a : a;
        babs = (sign && b[31]) ? -b : b;

        // rem < |b| before the shift, so the shifted value is below 2*|b| and
        // the difference lies in (-2^32, 2^32): bit 32 is a valid sign bit.
        rem_sh = {rem_q, quo_q[31]};
        trial  = rem_sh - {1'b0, babs_q};
        rem_d  = trial[32] ? rem_sh[31:0] : trial[31:0];
        quo_d  = {quo_q[30:0], ~trial[32]};

        lo_d = bzero_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_q : quo_q);
        hi_d = bzero_q ? a_q           : (rneg_q ? -rem_q : rem_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            babs_q  <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && ena) begin
                        qneg_q  <= sign & (a[31] ^ b[31]);
                        rneg_q  <= sign & a[31];
                        bzero_q <= (b == 32'd0);
                        a_q     <= a;
                        quo_q   <= aabs;
                        babs_q  <= babs;
                        rem_q   <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // done_q doubles as the second-cycle marker of FIX so the
                    // pulse is seen while busy is still high, never in IDLE.
                    if (!done_q) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Hi   = ena ? hi_q : 32'd0;
    assign Lo   = ena ? lo_q : 32'd0;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_div.sv
// ---------------------------------------------------------------------------
// tb_seq_div -- directed self-checking bench for seq_div.
//
// Runs hand-computed divisions (unsigned, signed mixed signs, edge operands,
// divide by zero), checks the start-to-done latency and busy window, and
// exercises start-while-busy, reset mid-division and enable gating.
// ---------------------------------------------------------------------------
module tb_seq_div;

    logic        clk;
    logic        reset;
    logic        ena;
    logic        sign;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        busy;
    logic        done;

    int total;
    int bad;

    seq_div dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .sign  (sign),
        .start (start),
        .a     (a),
        .b     (b),
        .Hi    (Hi),
        .Lo    (Lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request that edge E0 samples; returns 1 time unit after E0.
    task automatic go(input logic s, input logic [31:0] aa, input logic [31:0] bb);
        sign  = s;
        a     = aa;
        b     = bb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done after go(); k is the edge index at which done was seen.
    // At inj_k a conflicting start is driven for one edge.
    task automatic wait_done(input int inj_k, output int k, output int busy_low);
        k = 0;
        busy_low = 0;
        if (busy !== 1'b1) busy_low++;
        while (done !== 1'b1 && k < 60) begin
            if (k == inj_k) begin
                start = 1'b1;
                sign  = 1'b1;
                a     = 32'd50;
                b     = 32'd5;
            end
            tick();
            start = 1'b0;
            k++;
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] aa,
                           input logic [31:0] bb, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int inj_k);
        int k;
        int bl;
        go(s, aa, bb);
        wait_done(inj_k, k, bl);
        check({tag, "_latency"}, k, 33);
        check({tag, "_busy_window"}, bl, 0);
        check({tag, "_lo"}, Lo, exp_lo);
        check({tag, "_hi"}, Hi, exp_hi);
        tick();
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        check({tag, "_lo_hold"}, Lo, exp_lo);
    endtask

    initial begin
        int k;
        int done_seen;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ena   = 1'b1;
        sign  = 1'b0;
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        // start held with reset must be dropped
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("rst_start_dropped", {31'd0, busy}, 32'd0);

        run_div("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          -1);
        run_div("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  -1);
        run_div("s_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          -1);
        run_div("u_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          -1);
        run_div("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          -1);
        run_div("u_max_max", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          -1);
        run_div("u_dz",      1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  -1);
        run_div("s_dz",      1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  -1);
        run_div("s_dz_neg",  1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  -1);
        run_div("s_m100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  -1);

        // second start at cycle 10 is ignored
        run_div("busy_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 9);

        // reset at cycle 20 aborts and clears the results
        go(1'b0, 32'd1000, 32'd3);
        for (int i = 1; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", Hi, 32'd0);
        check("midrst_lo", Lo, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);

        // enable gating during a division
        go(1'b0, 32'd100, 32'd7);
        for (k = 1; k <= 5; k++) tick();
        ena = 1'b0;
        for (; k <= 33; k++) tick();
        check("ena_done_k33", {31'd0, done}, 32'd1);
        check("ena_low_hi", Hi, 32'd0);
        check("ena_low_lo", Lo, 32'd0);
        tick();
        check("ena_low_idle", {31'd0, busy}, 32'd0);
        ena = 1'b1;
        #1;
        check("ena_up_lo", Lo, 32'd14);
        check("ena_up_hi", Hi, 32'd2);

        // start with ena low is ignored
        ena   = 1'b0;
        sign  = 1'b0;
        a     = 32'd9;
        b     = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ena_start_busy", {31'd0, busy}, 32'd0);
        tick();
        ena = 1'b1;
        #1;
        check("ena_start_busy2", {31'd0, busy}, 32'd0);
        check("ena_hold_lo", Lo, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
